// File: rtl/adder_subtractor_checker.sv
// adder_subtractor_checker
//
// Stimulus/response checker for an n-bit adder/subtractor with signed
// overflow. On start it walks every {add_n, x, y} combination (adds first,
// y fastest), waits SETTLE cycles per vector for the responder to settle,
// then compares s / c_out / overflow against an internal reference.
// Mismatches are counted and the first failing vector is captured.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   start             : begin a sweep (honoured only when idle or done)
//   x_out, y_out      : operands driven to the block under test
//   add_n_out         : 0 = add, 1 = subtract
//   s_in, c_out_in,
//   overflow_in       : responses from the block under test
//   busy, done, pass  : sweep status; pass = done with zero mismatches
//   err_count         : number of mismatching vectors in the last sweep
//   first_fail_valid  : at least one mismatch captured
//   first_fail_vec    : {add_n, x, y} of the first mismatch
module adder_subtractor_checker #(
    parameter int n      = 4,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [n-1:0]   x_out,
    output logic [n-1:0]   y_out,
    output logic           add_n_out,
    input  logic [n-1:0]   s_in,
    input  logic           c_out_in,
    input  logic           overflow_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*n+1:0] err_count,
    output logic           first_fail_valid,
    output logic [2*n:0]   first_fail_vec
);

    localparam int VW = 2 * n + 1;
    localparam int EW = 2 * n + 2;
    // Counter only needs to reach SETTLE-1; keep at least one bit so the
    // SETTLE = 0 build still elaborates (WAIT is unreachable there).
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [VW-1:0] V_LAST    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [VW-1:0]  v;
    logic [WW-1:0]  wait_cnt;

    // The vector index maps straight onto the operand outputs.
    assign add_n_out = v[2*n];
    assign x_out     = v[2*n-1:n];
    assign y_out     = v[n-1:0];

    // Reference model: subtract is x + ~y + 1, so carry = 1 means no borrow.
    logic [n:0] sum_add, sum_sub, sum_ref;
    logic       ovf_ref, mismatch;

    assign sum_add = {1'b0, x_out} + {1'b0, y_out};
    assign sum_sub = {1'b0, x_out} + {1'b0, ~y_out} + (n+1)'(1);
    assign sum_ref = add_n_out ? sum_sub : sum_add;

    always_comb begin
        if (add_n_out)
            ovf_ref = (x_out[n-1] != y_out[n-1]) && (sum_ref[n-1] != x_out[n-1]);
        else
            ovf_ref = (x_out[n-1] == y_out[n-1]) && (sum_ref[n-1] != x_out[n-1]);
    end

    assign mismatch = (s_in != sum_ref[n-1:0]) || (c_out_in != sum_ref[n]) ||
                      (overflow_in != ovf_ref);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
            S_DRIVE:        state_nxt = (SETTLE > 0) ? S_WAIT : S_CHECK;
            S_WAIT:         if (wait_cnt == WAIT_LAST) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = (v == V_LAST) ? S_DONE : S_DRIVE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Datapath: vector index, settle counter, error bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            v                <= '0;
            wait_cnt         <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        v                <= '0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                S_DRIVE: wait_cnt <= '0;
                S_WAIT:  wait_cnt <= wait_cnt + WW'(1);
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + EW'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= v;
                        end
                    end
                    // Last vector stays on the outputs while in DONE.
                    if (v != V_LAST) v <= v + VW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_adder_subtractor_checker.sv
module tb_adder_subtractor_checker;

    localparam int N     = 4;
    localparam int S     = 1;
    localparam int NV    = 1 << (2 * N + 1);
    localparam int VPC   = S + 2;
    localparam int TOTAL = NV * VPC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    // instance A: defaults
    logic [N-1:0]   x_out, y_out, s_a;
    logic           add_n_out, c_a, o_a, busy, done, pass, ffv;
    logic [2*N+1:0] err_count;
    logic [2*N:0]   ffvec;

    adder_subtractor_checker #(.n(N), .SETTLE(S)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .x_out(x_out), .y_out(y_out), .add_n_out(add_n_out),
        .s_in(s_a), .c_out_in(c_a), .overflow_in(o_a),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_valid(ffv), .first_fail_vec(ffvec)
    );

    // instance B: n = 2, SETTLE = 0
    logic       start2 = 1'b0;
    logic [1:0] x2, y2, s2;
    logic       add_n2, c2, o2, busy2, done2, pass2, ffv2;
    logic [5:0] err2;
    logic [4:0] ffvec2;

    adder_subtractor_checker #(.n(2), .SETTLE(0)) dut_b (
        .clk(clk), .rst(rst), .start(start2),
        .x_out(x2), .y_out(y2), .add_n_out(add_n2),
        .s_in(s2), .c_out_in(c2), .overflow_in(o2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-integer adder/subtractor: returns s | c<<w | ovf<<(w+1)
    function automatic int ref_resp(input int w, input int v);
        int mask, half, x, y, sx, sy, s, c, sr, o;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        x  = (v >> w) & mask;
        y  = v & mask;
        sx = (x >= half) ? x - (1 << w) : x;
        sy = (y >= half) ? y - (1 << w) : y;
        if (((v >> (2 * w)) & 1) == 0) begin
            s = (x + y) & mask; c = (x + y) >> w; sr = sx + sy;
        end else begin
            s = (x - y) & mask; c = (x >= y) ? 1 : 0; sr = sx - sy;
        end
        o = (sr > half - 1 || sr < -half) ? 1 : 0;
        return s | (c << w) | (o << (w + 1));
    endfunction

    // Responder models (with injectable faults for instance A)
    int         fault_kind = 0;
    logic [2:0] cor [NV];
    bit         bad [NV];
    int         ra, vi, rb;

    always_comb begin
        vi  = int'({add_n_out, x_out, y_out});
        ra  = ref_resp(N, vi);
        s_a = ra[N-1:0];
        c_a = ra[N];
        o_a = ra[N+1];
        case (fault_kind)
            1: o_a = 1'b0;
            2: s_a[0] = ~s_a[0];
            3: begin
                s_a[0] = s_a[0] ^ cor[vi][0];
                c_a    = c_a ^ cor[vi][1];
                o_a    = o_a ^ cor[vi][2];
            end
            default: ;
        endcase
    end

    always_comb begin
        rb = ref_resp(2, int'({add_n2, x2, y2}));
        s2 = rb[1:0];
        c2 = rb[2];
        o2 = rb[3];
    end

    task automatic set_fault(input int kind);
        int r;
        fault_kind = kind;
        for (int v = 0; v < NV; v++) begin
            cor[v] = 3'd0;
            if (kind == 3 && $urandom_range(0, 15) == 0) cor[v] = 3'($urandom_range(1, 7));
            r = ref_resp(N, v);
            case (kind)
                1:       bad[v] = r[N+1];
                2:       bad[v] = 1'b1;
                3:       bad[v] = (cor[v] != 3'd0);
                default: bad[v] = 1'b0;
            endcase
        end
    endtask

    // Cycle-level expectation for instance A, derived from elapsed time
    typedef enum {M_UNK, M_ZERO, M_SWEEP, M_DONE} mode_t;
    mode_t mode = M_UNK;
    int    k = 0, exp_err = 0, exp_first = 0, vec, j;
    bit    exp_ffv = 0;
    bit    bad_snap [NV];

    always @(negedge clk) begin
        if (mode != M_UNK) begin
            vec = (mode == M_SWEEP) ? k / VPC : (mode == M_DONE) ? NV - 1 : 0;
            chk("x_out", 32'(x_out), (vec >> N) & 15);
            chk("y_out", 32'(y_out), vec & 15);
            chk("add_n", 32'(add_n_out), (vec >> (2 * N)) & 1);
            chk("busy", 32'(busy), (mode == M_SWEEP) ? 1 : 0);
            chk("done", 32'(done), (mode == M_DONE) ? 1 : 0);
            chk("pass", 32'(pass), (mode == M_DONE && exp_err == 0) ? 1 : 0);
            chk("err_count", 32'(err_count), exp_err);
            chk("ff_valid", 32'(ffv), 32'(exp_ffv));
            chk("ff_vec", 32'(ffvec), exp_first);
        end
        // advance to what the next rising edge must produce
        if (rst) begin
            mode = M_ZERO; exp_err = 0; exp_ffv = 0; exp_first = 0;
        end else if (mode == M_SWEEP) begin
            k++;
            if (k % VPC == 0) begin
                j = k / VPC - 1;
                if (bad_snap[j]) begin
                    exp_err++;
                    if (!exp_ffv) begin exp_ffv = 1; exp_first = j; end
                end
            end
            if (k == TOTAL) mode = M_DONE;
        end else if ((mode == M_ZERO || mode == M_DONE) && start) begin
            mode = M_SWEEP; k = 0; exp_err = 0; exp_ffv = 0; exp_first = 0;
            bad_snap = bad;
        end
    end

    task automatic run_sweep(output int cyc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < TOTAL + 50) begin
            @(posedge clk); #1 cyc++;
        end
    endtask

    int lat, nbad, rises, run, maxrun;

    initial begin
        set_fault(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err_count), 0);
        chk("reset_x", 32'(x_out), 0);

        // clean responder
        run_sweep(lat);
        chk("clean_latency", lat, 1536);
        chk("clean_pass", 32'(pass), 1);
        chk("clean_err", 32'(err_count), 0);
        chk("clean_ffv", 32'(ffv), 0);

        // overflow stuck at 0
        set_fault(1);
        run_sweep(lat);
        chk("ovf0_err", 32'(err_count), 128);
        chk("ovf0_vec", 32'(ffvec), 32'h017);
        chk("ovf0_pass", 32'(pass), 0);

        // s[0] inverted
        set_fault(2);
        run_sweep(lat);
        chk("s0inv_err", 32'(err_count), 512);
        chk("s0inv_vec", 32'(ffvec), 0);
        chk("s0inv_ffv", 32'(ffv), 1);

        // random corruption patterns
        for (int it = 0; it < 3; it++) begin
            set_fault(3);
            nbad = 0;
            for (int v = 0; v < NV; v++) if (bad[v]) nbad++;
            run_sweep(lat);
            chk("rand_latency", lat, TOTAL);
            chk("rand_err", 32'(err_count), nbad);
        end

        // start held high across two full sweeps
        set_fault(0);
        @(posedge clk); #1 start = 1'b1;
        rises = 0; run = 0; maxrun = 0;
        for (int c = 0; c < 2 * TOTAL + 5; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (run == 0) rises++;
                run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
        end
        start = 1'b0;
        chk("held_done_rises", rises, 2);
        chk("held_done_width", maxrun, 1);
        lat = 0;
        while (done !== 1'b1 && lat < TOTAL + 50) begin
            @(posedge clk); #1 lat++;
        end
        chk("held_final_done", 32'(done), 1);
        chk("held_final_err", 32'(err_count), 0);

        // reset mid-sweep
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (699) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_vec", 32'({add_n_out, x_out, y_out}), 0);
        chk("abort_err", 32'(err_count), 0);
        run_sweep(lat);
        chk("after_abort_latency", lat, 1536);
        chk("after_abort_pass", 32'(pass), 1);

        // n = 2, SETTLE = 0 instance
        @(posedge clk); #1 start2 = 1'b1;
        chk("b_busy_on_start", 32'(busy2), 0);
        @(posedge clk); #1 start2 = 1'b0;
        chk("b_busy", 32'(busy2), 1);
        lat = 0;
        while (done2 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1 lat++;
        end
        chk("b_latency", lat, 64);
        chk("b_pass", 32'(pass2), 1);
        chk("b_err", 32'(err2), 0);
        chk("b_ffv", 32'(ffv2), 0);
        chk("b_last_vec", 32'({add_n2, x2, y2}), 31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_subtractor_checker.md
# adder_subtractor_checker

Self-checking stimulus and response block for the n-bit `adder_subtractor_with_overflow`. It drives the adder/subtractor's `x`, `y` and `add_n` inputs and checks its `s`, `c_out` and `overflow` responses, so it sits at the opposite end of that interface from the block under test. On `start` it sweeps every operand pair in both add and subtract modes and compares each response against an internal reference model. It counts mismatches, captures the first failing vector, and reports pass/fail, so the same check runs in simulation or on an FPGA bring-up board.

## Interface
- `n`, default 4: operand width; vector space is 2^(2n+1).
- `SETTLE`, default 1: idle cycles (≥0) between driving a vector and sampling the response.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: begin a sweep; sampled only in IDLE or DONE.
- `x_out` output n: operand x to DUT.
- `y_out` output n: operand y to DUT.
- `add_n_out` output 1: 0 = add, 1 = subtract.
- `s_in` input n: DUT sum/difference.
- `c_out_in` input 1: DUT carry out.
- `overflow_in` input 1: DUT signed overflow.
- `busy` output 1: sweep in progress.
- `done` output 1: sweep complete; held until next start or reset.
- `pass` output 1: `done` and `err_count == 0`.
- `err_count` output 2n+2: number of mismatching vectors; no saturation needed.
- `first_fail_valid` output 1: at least one mismatch recorded.
- `first_fail_vec` output 2n+1: {add_n, x, y} of first mismatch.

## Operation
- Vector index `v` (2n+1 bits): `add_n_out = v[2n]`, `x_out = v[2n-1:n]`, `y_out = v[n-1:0]`.
- Sweep order runs v = 0 … 2^(2n+1)−1, so all add vectors come before all subtract vectors, with y incrementing fastest.
- Reference model for add (`add_n = 0`):
  - {c, s} = x + y
  - ovf = (x[n-1] == y[n-1]) && (s[n-1] != x[n-1])
- Reference model for subtract (`add_n = 1`):
  - {c, s} = x + ~y + 1, so c = 1 means no borrow
  - ovf = (x[n-1] != y[n-1]) && (s[n-1] != x[n-1])
- A mismatch is any difference in s, c or ovf. Each mismatch increments `err_count` by exactly 1 per vector.
- On the first mismatch only, load `first_fail_vec` and set `first_fail_valid`.
- FSM states:
  - IDLE: on `start`, go to DRIVE, load v = 0, clear `err_count`, `first_fail_valid`, `first_fail_vec` and `done`, set `busy`.
  - DRIVE: vector is on the outputs; one cycle. Go to WAIT if `SETTLE > 0`, else to CHECK.
  - WAIT: count `SETTLE` cycles, then go to CHECK.
  - CHECK: sample `s_in`, `c_out_in` and `overflow_in`, compare, update counters. If v is the last vector, go to DONE; otherwise increment v and go to DRIVE.
  - DONE: `busy` = 0, `done` = 1. On `start`, behave exactly as IDLE with `start`.
- `start` while `busy` is ignored.
- Outputs hold the last vector in DONE.

## Timing
- Reset values: all outputs 0, state IDLE, v = 0.
- Reset mid-sweep aborts immediately; next cycle is IDLE with all outputs 0.
- `rst` has priority over `start` on the same edge.
- The edge that samples `start` sets `busy` = 1 and drives vector 0.
- Each vector occupies `SETTLE` + 2 cycles; the DUT inputs change only on entry to DRIVE.
- Sampling happens on the edge leaving CHECK.
- `done` rises 2^(2n+1)·(`SETTLE`+2) cycles after the start edge. For defaults: 512·3 = 1536 cycles.
- `busy` and `done` are never both 1. `pass` is combinational from `done` and `err_count`.
- `err_count` and first-fail fields are final when `done` rises and are stable in DONE.

## Test plan
- Correct DUT, defaults, one `start` pulse:
  - `busy` rises on the start edge.
  - `done` and `pass` = 1 exactly 1536 cycles later.
  - `err_count` = 0, `first_fail_valid` = 0.
- DUT `overflow` stuck at 0:
  - `err_count` = 128 (64 add + 64 subtract).
  - `first_fail_vec` = 9'h017 (add, x = 1, y = 7); `pass` = 0.
- DUT `s[0]` inverted:
  - `err_count` = 512.
  - `first_fail_vec` = 0.
- `start` held high throughout a sweep with a correct DUT:
  - Restart occurs only once DONE is reached.
  - `done` remains 1 for at most one cycle, and the second sweep again ends with `err_count` = 0.
- `rst` asserted at cycle 700 of a sweep:
  - All outputs 0 next cycle.
  - A new `start` gives a full 1536-cycle sweep from v = 0.
- `SETTLE` = 0, n = 2, correct DUT:
  - `done` after 32·2 = 64 cycles.
  - `pass` = 1.
